// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: one request/response read of instruction memory at PC,
// latches the word into IR and hands PC+4 plus a one-cycle write enable back to the PC.
module ifetch_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] IR,
  output logic [31:0] NPC_seq,
  output logic        pc_write,
  output logic        fetch_done,
  output logic        misaligned,
  output logic        bus_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

  logic [2:0]  state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;

  // Next-state decode of the fetch sequencer
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          if (PC[1:0] == 2'b00) begin
            fetch_addr_d = PC;
            state_d      = S_REQ;
          end else begin
            misaligned_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // Once accepted, a flushed request still owes a response, hence DRAIN
        if (mem_ready) begin
          cnt_d   = 8'd0;
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            ir_d    = mem_rdata;
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (cnt_q == TO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= 32'h0000_0000;
      ir_q         <= 32'h0000_0000;
      cnt_q        <= 8'd0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      ir_q         <= ir_d;
      cnt_q        <= cnt_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = fetch_addr_q;
  assign IR         = ir_q;
  assign NPC_seq    = fetch_addr_q + 32'd4;
  assign pc_write   = (state_q == S_DONE);
  assign fetch_done = (state_q == S_DONE);
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected IR/NPC pushed at fetch_start,
// popped and compared whenever the DUT pulses fetch_done.
module tb_ifetch_unit;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        fetch_start;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] IR;
  logic [31:0] NPC_seq;
  logic        pc_write;
  logic        fetch_done;
  logic        misaligned;
  logic        bus_err;
  logic        busy;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  sb_t         sb[$];
  logic [31:0] last_ir;

  ifetch_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC         (PC),
    .fetch_start(fetch_start),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .IR         (IR),
    .NPC_seq    (NPC_seq),
    .pc_write   (pc_write),
    .fetch_done (fetch_done),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every fetch_done must match the oldest pending fetch
  always @(negedge clk) begin
    if (!rst && fetch_done) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check_val("sb_ir", IR, e.ir);
        check_val("sb_npc", NPC_seq, e.npc);
        check_val("sb_pc_write", {31'd0, pc_write}, 32'd1);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ir"}, IR, 32'h0000_0000);
    check_val({tag, "_npc"}, NPC_seq, 32'h0000_0004);
    check_val({tag, "_addr"}, mem_addr, 32'h0000_0000);
    check_val({tag, "_ctl"}, {26'd0, mem_req, pc_write, fetch_done, misaligned, bus_err, busy}, 32'd0);
  endtask

  // Full fetch with rdy_wait cycles of mem_ready=0 and rv_wait WAIT cycles before rvalid
  task automatic do_fetch(input logic [31:0] pc, input int rdy_wait, input int rv_wait,
                          input logic [31:0] data);
    sb_t e;
    e.ir  = data;
    e.npc = pc + 32'd4;
    sb.push_back(e);
    PC = pc; fetch_start = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b0;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < rdy_wait; i++) begin
      check_val("req_hold", {31'd0, mem_req}, 32'd1);
      check_val("req_addr", mem_addr, pc);
      check_val("req_busy", {31'd0, busy}, 32'd1);
      step();
    end
    check_val("req_last", {31'd0, mem_req}, 32'd1);
    check_val("req_addr_last", mem_addr, pc);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < rv_wait; i++) begin
      check_val("wait_busy", {31'd0, busy}, 32'd1);
      check_val("wait_noreq", {31'd0, mem_req}, 32'd0);
      check_val("wait_nodone", {31'd0, fetch_done}, 32'd0);
      check_val("wait_nobuserr", {31'd0, bus_err}, 32'd0);
      step();
    end
    check_val("pre_done", {31'd0, fetch_done}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = data;
    step();
    mem_rvalid = 1'b0; mem_rdata = $urandom();
    check_val("done_pulse", {30'd0, fetch_done, pc_write}, 32'd3);
    check_val("done_busy", {31'd0, busy}, 32'd1);
    step();
    check_val("done_single", {30'd0, fetch_done, pc_write}, 32'd0);
    check_val("post_idle", {31'd0, busy}, 32'd0);
    check_val("post_buserr", {31'd0, bus_err}, 32'd0);
    last_ir = data;
  endtask

  initial begin
    rst = 1'b1; PC = 32'd0; fetch_start = 1'b0; flush = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    last_ir = 32'd0;
    step();
    step();
    rst = 1'b0;
    check_reset_vals("reset");

    // Basic fetch and backpressure
    do_fetch(32'h0000_0040, 0, 0, 32'h2008_0005);
    do_fetch(32'h0000_0080, 4, 2, 32'hA5A5_0F0F);

    // Misaligned start: pulse only, no request, IR and fetch address untouched
    PC = 32'h0000_0042; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_val("mis_pulse", {31'd0, misaligned}, 32'd1);
    check_val("mis_noreq", {30'd0, mem_req, busy}, 32'd0);
    step();
    check_val("mis_single", {31'd0, misaligned}, 32'd0);
    check_val("mis_noreq2", {31'd0, mem_req}, 32'd0);
    check_val("mis_ir", IR, last_ir);
    check_val("mis_npc", NPC_seq, 32'h0000_0084);

    // Wrap of NPC
    do_fetch(32'hFFFF_FFFC, 1, 0, 32'h1234_5678);
    check_val("wrap_npc", NPC_seq, 32'h0000_0000);

    // Timeout: no response for 16 WAIT cycles
    PC = 32'h0000_0010; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check_val("to_wait_busy", {31'd0, busy}, 32'd1);
      check_val("to_no_buserr", {31'd0, bus_err}, 32'd0);
      check_val("to_no_done", {31'd0, pc_write}, 32'd0);
      step();
    end
    check_val("to_buserr", {31'd0, bus_err}, 32'd1);
    check_val("to_idle", {31'd0, busy}, 32'd0);
    check_val("to_ir", IR, last_ir);
    step();
    check_val("to_buserr_single", {31'd0, bus_err}, 32'd0);

    // Response on the 16th WAIT cycle still completes
    do_fetch(32'h0000_0020, 0, 15, 32'h0BAD_F00D);

    // Flush in WAIT, late response discarded through DRAIN
    PC = 32'h0000_0100; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("drain_busy", {31'd0, busy}, 32'd1);
    check_val("drain_noreq", {31'd0, mem_req}, 32'd0);
    step();
    check_val("drain_busy2", {31'd0, busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check_val("drain_idle", {31'd0, busy}, 32'd0);
    check_val("drain_nodone", {31'd0, fetch_done}, 32'd0);
    check_val("drain_ir", IR, last_ir);
    check_val("drain_npc", NPC_seq, 32'h0000_0104);
    step();
    check_val("drain_ir2", IR, last_ir);

    // Flush in REQ without acceptance: straight back to IDLE
    PC = 32'h0000_0200; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("reqflush_idle", {30'd0, mem_req, busy}, 32'd0);
    step();
    check_val("reqflush_stay", {31'd0, busy}, 32'd0);

    // Reset in WAIT; in-flight response then ignored
    PC = 32'h0000_0300; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("midrst");
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    check_reset_vals("midrst_rv");
    last_ir = 32'd0;

    // Back-to-back fetch right after reset recovery
    do_fetch(32'h0000_0044, 2, 1, 32'h0000_1111);

    check_val("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch sequencer for the multicycle CPU. It sits directly downstream of the PC register. It takes the current PC, runs one instruction-memory read with a request/response handshake, and latches the returned word into the instruction register. On completion it drives the sequential next-PC (PC+4) and a one-cycle PC write enable back toward the PC register's write-enable/NPC path.

## Interface
Parameters:
- TIMEOUT, 16: maximum WAIT cycles without a response before a bus error; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- PC  in  32  current program counter
- fetch_start  in  1  controller request to fetch at PC; sampled only in IDLE
- flush  in  1  abort the current fetch
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  read address, word aligned
- mem_ready  in  1  memory accepts the request this cycle when mem_req=1
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- IR  out  32  instruction register
- NPC_seq  out  32  fetch address + 4
- pc_write  out  1  one-cycle PC write enable
- fetch_done  out  1  one-cycle pulse: IR updated
- misaligned  out  1  one-cycle pulse: fetch_start with PC[1:0]≠0
- bus_err  out  1  one-cycle pulse: response timeout
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE:
  - fetch_start=1 and PC[1:0]=0: latch fetch_addr<=PC, go to REQ.
  - fetch_start=1 and PC[1:0]≠0: misaligned=1 next cycle, stay in IDLE, no memory request issued.
  - mem_rvalid is ignored.
- REQ: mem_req=1, mem_addr=fetch_addr.
  - mem_ready=1: go to WAIT and clear the timeout counter.
  - flush=1 with mem_ready=0: go to IDLE, no request is outstanding.
  - flush=1 with mem_ready=1: the request is accepted, go to DRAIN.
- WAIT:
  - mem_rvalid=1 and flush=0: IR<=mem_rdata, go to DONE.
  - flush=1 and mem_rvalid=1: the response is consumed and discarded, go to IDLE.
  - flush=1 without mem_rvalid: go to DRAIN.
  - Otherwise increment the counter. When counter = TIMEOUT-1 and mem_rvalid=0: bus_err=1 next cycle, go to IDLE, IR unchanged.
- DRAIN: wait for mem_rvalid, discard the data, go to IDLE. No timeout applies; flush has no further effect.
- DONE: fetch_done=1 and pc_write=1 for exactly this cycle, then go to IDLE.
- Only DONE writes IR.
- fetch_start outside IDLE is ignored and is not queued.
- mem_rvalid in REQ is a protocol violation and is ignored.
- NPC_seq = fetch_addr + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- mem_addr = fetch_addr at all times. mem_req is decoded from state.

## Timing
- Reset values: state=IDLE, IR=0, fetch_addr=0 (so NPC_seq=4, mem_addr=0), counter=0. mem_req, pc_write, fetch_done, misaligned, bus_err and busy are all 0.
- rst mid-operation goes to IDLE on the next edge. A response still in flight then arrives in IDLE and is ignored.
- Minimum latency is 3 cycles, from fetch_start sampled (edge 0) to fetch_done high after edge 3:
  - REQ after edge 1
  - WAIT after edge 2
  - DONE after edge 3
- Each extra cycle of mem_ready=0 or mem_rvalid=0 adds one cycle.
- misaligned and bus_err go high in the cycle after the triggering edge, for one cycle.
- pc_write and fetch_done assert in the same cycle that IR shows the new word. The earliest next fetch_start is accepted in the cycle after DONE.
- mem_rvalid can be accepted no earlier than the cycle after mem_ready.

## Test plan
- Basic fetch: PC=0x0000_0040, pulse fetch_start, mem_ready=1 immediately, mem_rvalid one cycle later with mem_rdata=0x2008_0005. Required: IR=0x2008_0005, NPC_seq=0x0000_0044, and pc_write/fetch_done high for one cycle, exactly 3 cycles after start.
- Backpressure: mem_ready low for 4 cycles, then mem_rvalid after 2 more WAIT cycles. Required: mem_req held with a stable mem_addr, fetch_done 9 cycles after start, busy high throughout.
- Misaligned and wrap: PC=0x0000_0042 gives a misaligned pulse, no mem_req, IR unchanged. PC=0xFFFF_FFFC fetch gives NPC_seq=0x0000_0000.
- Timeout: TIMEOUT=16, request accepted, no mem_rvalid. Required: bus_err pulse 16 cycles after entering WAIT, no pc_write, IR unchanged. Rerun with mem_rvalid on the 16th WAIT cycle: the fetch completes normally and bus_err stays 0.
- Flush: flush in WAIT goes to DRAIN, and a late mem_rvalid with 0xDEAD_BEEF is discarded (IR unchanged, no fetch_done). flush in REQ with mem_ready=0 returns to IDLE with no DRAIN.
- Reset mid-fetch: assert rst in WAIT. Required: all outputs at reset values next cycle, and a following mem_rvalid is ignored.
